// File: rtl/ov5640_dvp_emu.sv
// OV5640-style DVP camera emulator: free-running pclk at half sys_clk, vsync/href framing
// and RGB565 test patterns streamed as two bytes per pixel, high byte first.
module ov5640_dvp_emu #(
  parameter int H_ACTIVE = 1024,
  parameter int H_BLANK  = 256,
  parameter int V_ACTIVE = 768,
  parameter int VS_LINES = 4,
  parameter int V_BP     = 16,
  parameter int V_FP     = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        en,
  input  logic [1:0]  mode,
  input  logic [15:0] solid_rgb,
  output logic        cam_pclk,
  output logic        cam_vsync,
  output logic        cam_href,
  output logic [7:0]  cam_data,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);

  localparam int LINE  = 2 * H_ACTIVE + H_BLANK;
  localparam int BAR_W = H_ACTIVE / 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_VSYNC  = 3'd1,
    S_VBP    = 3'd2,
    S_ACTIVE = 3'd3,
    S_VFP    = 3'd4
  } state_t;

  state_t      r_state;
  logic        r_pclk;
  logic [15:0] r_hcnt;
  logic [15:0] r_lcnt;
  logic [1:0]  r_mode;
  logic [15:0] r_solid;
  logic        r_vsync;
  logic        r_href;
  logic [7:0]  r_data;
  logic        r_busy;
  logic        r_frame_done;
  logic [15:0] r_frame_cnt;

  state_t      w_state_nx;
  logic [15:0] w_hcnt_nx;
  logic [15:0] w_lcnt_nx;
  logic [15:0] w_lines_m1;
  logic        w_frame_end;
  logic        w_latch;
  logic [14:0] w_x;
  logic [7:0]  w_y;
  logic [2:0]  w_bar;
  logic [15:0] w_pixel;
  logic        w_href_nx;
  logic [7:0]  w_data_nx;

  function automatic logic [15:0] colour_bar(input logic [2:0] bar);
    logic [15:0] c;
    case (bar)
      3'd0:    c = 16'hFFFF;
      3'd1:    c = 16'hFFE0;
      3'd2:    c = 16'h07FF;
      3'd3:    c = 16'h07E0;
      3'd4:    c = 16'hF81F;
      3'd5:    c = 16'hF800;
      3'd6:    c = 16'h001F;
      3'd7:    c = 16'h0000;
      default: c = 16'h0000;
    endcase
    return c;
  endfunction

  // Number of lines (minus one) spent in the current framing state.
  always_comb begin
    w_lines_m1 = 16'd0;
    case (r_state)
      S_VSYNC:  w_lines_m1 = 16'(VS_LINES - 1);
      S_VBP:    w_lines_m1 = 16'(V_BP - 1);
      S_ACTIVE: w_lines_m1 = 16'(V_ACTIVE - 1);
      S_VFP:    w_lines_m1 = 16'(V_FP - 1);
      default:  w_lines_m1 = 16'd0;
    endcase
  end

  // Next-state and position counters, evaluated for the coming fall edge.
  always_comb begin
    w_state_nx  = r_state;
    w_hcnt_nx   = r_hcnt;
    w_lcnt_nx   = r_lcnt;
    w_frame_end = 1'b0;
    w_latch     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_hcnt_nx = 16'd0;
        w_lcnt_nx = 16'd0;
        if (en) begin
          w_state_nx = S_VSYNC;
          w_latch    = 1'b1;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_VSYNC, S_VBP, S_ACTIVE, S_VFP: begin
        if (r_hcnt == 16'(LINE - 1)) begin
          w_hcnt_nx = 16'd0;
          if (r_lcnt == w_lines_m1) begin
            w_lcnt_nx = 16'd0;
            case (r_state)
              S_VSYNC:  w_state_nx = S_VBP;
              S_VBP:    w_state_nx = S_ACTIVE;
              S_ACTIVE: w_state_nx = S_VFP;
              S_VFP: begin
                w_frame_end = 1'b1;
                if (en) begin
                  w_state_nx = S_VSYNC;
                  w_latch    = 1'b1;
                end else begin
                  w_state_nx = S_IDLE;
                end
              end
              default:  w_state_nx = S_IDLE;
            endcase
          end else begin
            w_lcnt_nx = r_lcnt + 16'd1;
          end
        end else begin
          w_hcnt_nx = r_hcnt + 16'd1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign w_x   = w_hcnt_nx[15:1];
  assign w_y   = w_lcnt_nx[7:0];
  assign w_bar = 3'(w_x / 15'(BAR_W));

  // Pattern generator; uses the mode/colour captured at frame start.
  always_comb begin
    w_pixel = 16'h0000;
    case (r_mode)
      2'd0:    w_pixel = {w_y, w_x[7:0]};
      2'd1:    w_pixel = colour_bar(w_bar);
      2'd2:    w_pixel = r_solid;
      2'd3:    w_pixel = (w_x[4] ^ w_y[4]) ? 16'h0000 : 16'hFFFF;
      default: w_pixel = 16'h0000;
    endcase
  end

  // Byte lane select: even pclk of a pixel carries the high byte.
  always_comb begin
    w_href_nx = (w_state_nx == S_ACTIVE) && (w_hcnt_nx < 16'(2 * H_ACTIVE));
    w_data_nx = 8'h00;
    if (w_href_nx) begin
      w_data_nx = w_hcnt_nx[0] ? w_pixel[7:0] : w_pixel[15:8];
    end else begin
      w_data_nx = 8'h00;
    end
  end

  // Free-running pixel clock, first rise on the first edge after reset.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_pclk <= 1'b0;
    end else begin
      r_pclk <= ~r_pclk;
    end
  end

  // Framing state and registered outputs, updated only on pclk fall edges.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state     <= S_IDLE;
      r_hcnt      <= 16'd0;
      r_lcnt      <= 16'd0;
      r_mode      <= 2'd0;
      r_solid     <= 16'h0000;
      r_vsync     <= 1'b0;
      r_href      <= 1'b0;
      r_data      <= 8'h00;
      r_busy      <= 1'b0;
      r_frame_cnt <= 16'h0000;
    end else if (r_pclk) begin
      r_state <= w_state_nx;
      r_hcnt  <= w_hcnt_nx;
      r_lcnt  <= w_lcnt_nx;
      r_vsync <= (w_state_nx == S_VSYNC);
      r_href  <= w_href_nx;
      r_data  <= w_data_nx;
      r_busy  <= (w_state_nx != S_IDLE);
      if (w_latch) begin
        r_mode  <= mode;
        r_solid <= solid_rgb;
      end
      if (w_frame_end) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  // End-of-frame strobe lasts exactly one sys_clk.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= r_pclk & w_frame_end;
    end
  end

  assign cam_pclk   = r_pclk;
  assign cam_vsync  = r_vsync;
  assign cam_href   = r_href;
  assign cam_data   = r_data;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_ov5640_dvp_emu.sv
// Directed self-checking bench for ov5640_dvp_emu with a 20-pclk line / 100-pclk frame.
module tb_ov5640_dvp_emu;

  localparam int LINE_P = 20;
  localparam int WAIT_MAX = 2000;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        en = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] solid_rgb = 16'h0000;
  logic        cam_pclk, cam_vsync, cam_href, busy, frame_done;
  logic [7:0]  cam_data;
  logic [15:0] frame_cnt;

  ov5640_dvp_emu #(
    .H_ACTIVE(8), .H_BLANK(4), .V_ACTIVE(2), .VS_LINES(1), .V_BP(1), .V_FP(1)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .en(en), .mode(mode), .solid_rgb(solid_rgb),
    .cam_pclk(cam_pclk), .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
    .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int t_start = 0;
  int t_done = 0;
  int fd_pulses = 0;
  int fd_samples = 0;
  int vs_rises = 0;
  logic prev_vs = 1'b0;
  logic prev_fd = 1'b0;
  logic [9:0] cap [0:99];
  logic [15:0] bars [0:7] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                              16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  always @(posedge sys_clk) cyc++;

  // Edge-count bookkeeping for vsync starts and frame_done pulses.
  always @(negedge sys_clk) begin
    if (cam_vsync && !prev_vs) begin
      t_start = cyc;
      vs_rises++;
    end
    if (frame_done) begin
      fd_samples++;
      if (!prev_fd) begin
        fd_pulses++;
        t_done = cyc;
      end
    end
    prev_vs = cam_vsync;
    prev_fd = frame_done;
  end

  task automatic tick();
    @(negedge sys_clk);
    #1;
  endtask

  function automatic logic [9:0] exp_pclk(input int md, input logic [15:0] solid, input int p);
    int l, h, x, y;
    logic vs, hr;
    logic [15:0] pix;
    logic [7:0] d;
    l = p / LINE_P;
    h = p % LINE_P;
    x = h / 2;
    y = l - 2;
    vs = (l == 0);
    hr = ((l == 2) || (l == 3)) && (h < 16);
    pix = 16'h0000;
    if (hr) begin
      case (md)
        0: pix = {y[7:0], x[7:0]};
        1: pix = bars[x];
        2: pix = solid;
        default: pix = (x[4] ^ y[4]) ? 16'h0000 : 16'hFFFF;
      endcase
    end
    d = hr ? ((h % 2 == 1) ? pix[7:0] : pix[15:8]) : 8'h00;
    return {vs, hr, d};
  endfunction

  task automatic capture(input int drop_at, input int chg_at);
    int n;
    n = 0;
    while (!(cam_pclk && cam_vsync) && n < WAIT_MAX) begin
      tick();
      n++;
    end
    n_checks++;
    if (n >= WAIT_MAX) begin
      n_fail++;
      $display("FAIL capture_start: vsync got=%0b want=1", cam_vsync);
    end
    for (int p = 0; p < 100; p++) begin
      cap[p] = {cam_vsync, cam_href, cam_data};
      if (p == drop_at) en = 1'b0;
      if (p == chg_at) begin
        mode = 2'd0;
        solid_rgb = 16'h0000;
      end
      tick();
      tick();
    end
  endtask

  task automatic check_frame(input string nm, input int md, input logic [15:0] solid);
    logic [9:0] e;
    for (int p = 0; p < 100; p++) begin
      e = exp_pclk(md, solid, p);
      n_checks++;
      if (cap[p] !== e) begin
        n_fail++;
        $display("FAIL %s pclk=%0d got{vs,href,data}=%h want=%h", nm, p, cap[p], e);
      end
    end
  endtask

  task automatic wait_pulses(input int target, input string nm);
    int n;
    n = 0;
    while (fd_pulses < target && n < WAIT_MAX) begin
      tick();
      n++;
    end
    n_checks++;
    if (fd_pulses < target) begin
      n_fail++;
      $display("FAIL %s timeout: frame_done pulses got=%0d want=%0d", nm, fd_pulses, target);
    end
  endtask

  task automatic test_reset();
    logic exp_pclk_v;
    sys_rst_n = 1'b0;
    en = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({cam_pclk, cam_vsync, cam_href, cam_data, busy, frame_done, frame_cnt} !== 29'd0) begin
      n_fail++;
      $display("FAIL reset_hold got=%h want=0",
               {cam_pclk, cam_vsync, cam_href, cam_data, busy, frame_done, frame_cnt});
    end
    sys_rst_n = 1'b1;
    exp_pclk_v = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if ({cam_pclk, cam_vsync, busy} !== {exp_pclk_v, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL idle_pclk step=%0d got{pclk,vs,busy}=%b want=%b", i,
                 {cam_pclk, cam_vsync, busy}, {exp_pclk_v, 1'b0, 1'b0});
      end
      exp_pclk_v = ~exp_pclk_v;
    end
  endtask

  task automatic test_mode0();
    mode = 2'd0;
    en = 1'b1;
    capture(5, -1);
    check_frame("mode0", 0, 16'h0000);
    wait_pulses(1, "mode0_done");
    tick();
    n_checks++;
    if (t_done - t_start != 200) begin
      n_fail++;
      $display("FAIL frame_len got=%0d want=200", t_done - t_start);
    end
    n_checks++;
    if ({frame_cnt, busy} !== {16'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL mode0_end got cnt=%0d busy=%0b want cnt=1 busy=0", frame_cnt, busy);
    end
  endtask

  task automatic test_mode1();
    mode = 2'd1;
    en = 1'b1;
    capture(5, -1);
    check_frame("mode1", 1, 16'h0000);
    wait_pulses(2, "mode1_done");
    tick();
    n_checks++;
    if (frame_cnt !== 16'd2) begin
      n_fail++;
      $display("FAIL mode1_cnt got=%0d want=2", frame_cnt);
    end
  endtask

  task automatic test_mode2_latch();
    mode = 2'd2;
    solid_rgb = 16'h1234;
    en = 1'b1;
    capture(-1, 30);
    check_frame("mode2_f1", 2, 16'h1234);
    capture(10, -1);
    check_frame("mode2_f2", 0, 16'h0000);
    wait_pulses(4, "mode2_done");
    tick();
    n_checks++;
    if (frame_cnt !== 16'd4) begin
      n_fail++;
      $display("FAIL mode2_cnt got=%0d want=4", frame_cnt);
    end
  endtask

  task automatic test_en_drop();
    int n, vs_hi, fp;
    fp = fd_pulses;
    en = 1'b1;
    n = 0;
    while (!cam_href && n < WAIT_MAX) begin
      tick();
      n++;
    end
    en = 1'b0;
    wait_pulses(fp + 1, "en_drop_done");
    tick();
    n_checks++;
    if ({frame_cnt, busy} !== {16'd5, 1'b0}) begin
      n_fail++;
      $display("FAIL en_drop_end got cnt=%0d busy=%0b want cnt=5 busy=0", frame_cnt, busy);
    end
    vs_hi = 0;
    repeat (300) begin
      tick();
      if (cam_vsync) vs_hi++;
    end
    n_checks++;
    if (vs_hi != 0) begin
      n_fail++;
      $display("FAIL en_drop_idle vsync-high samples got=%0d want=0", vs_hi);
    end
  endtask

  task automatic test_back_to_back();
    int fp0, s0, r0, t0, gaps, n;
    logic started;
    sys_rst_n = 1'b0;
    tick();
    tick();
    sys_rst_n = 1'b1;
    fp0 = fd_pulses;
    s0 = fd_samples;
    r0 = vs_rises;
    t0 = 0;
    gaps = 0;
    started = 1'b0;
    en = 1'b1;
    n = 0;
    while (n < 3 * WAIT_MAX) begin
      tick();
      n++;
      if (fd_pulses >= fp0 + 3) break;
      if (fd_pulses >= fp0 + 2) en = 1'b0;
      if (!started && cam_vsync) begin
        started = 1'b1;
        t0 = cyc;
      end
      if (started && !busy) gaps++;
    end
    n_checks++;
    if (fd_pulses - fp0 != 3) begin
      n_fail++;
      $display("FAIL b2b_pulses got=%0d want=3", fd_pulses - fp0);
    end
    n_checks++;
    if (fd_samples - s0 != 3) begin
      n_fail++;
      $display("FAIL b2b_pulse_width high-samples got=%0d want=3", fd_samples - s0);
    end
    n_checks++;
    if (gaps != 0 || vs_rises - r0 != 3) begin
      n_fail++;
      $display("FAIL b2b_gapless got gaps=%0d vsyncs=%0d want gaps=0 vsyncs=3", gaps, vs_rises - r0);
    end
    n_checks++;
    if (t_done - t0 != 600) begin
      n_fail++;
      $display("FAIL b2b_span got=%0d want=600", t_done - t0);
    end
    tick();
    n_checks++;
    if ({frame_cnt, busy} !== {16'd3, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_end got cnt=%0d busy=%0b want cnt=3 busy=0", frame_cnt, busy);
    end
  endtask

  task automatic test_reset_mid_frame();
    int n, fp;
    mode = 2'd3;
    en = 1'b1;
    n = 0;
    while (!cam_href && n < WAIT_MAX) begin
      tick();
      n++;
    end
    fp = fd_pulses;
    sys_rst_n = 1'b0;
    #1;
    n_checks++;
    if ({cam_pclk, cam_vsync, cam_href, cam_data, busy, frame_done, frame_cnt} !== 29'd0) begin
      n_fail++;
      $display("FAIL reset_async got=%h want=0",
               {cam_pclk, cam_vsync, cam_href, cam_data, busy, frame_done, frame_cnt});
    end
    repeat (4) tick();
    n_checks++;
    if (fd_pulses != fp || {cam_vsync, busy, frame_cnt} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_no_done got pulses=%0d cnt=%0d want pulses=%0d cnt=0",
               fd_pulses, frame_cnt, fp);
    end
    sys_rst_n = 1'b1;
    tick();
    n_checks++;
    if (cam_pclk !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_rise got=%0b want=1", cam_pclk);
    end
    capture(10, -1);
    check_frame("mode3_after_reset", 3, 16'h0000);
    wait_pulses(fp + 1, "reset_frame_done");
    tick();
    n_checks++;
    if (frame_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL reset_frame_cnt got=%0d want=1", frame_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_mode1();
    test_mode2_latch();
    test_en_drop();
    test_back_to_back();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
